mask_share_feeder: RTL and testbench

MASK_SHARE_FEEDER -- requirements
Module: mask_share_feeder

---
 rtl/mask_share_feeder.sv | 130 +++++++++++++
 tb/tb_mask_share_feeder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mask_share_feeder.sv
// Operand share generator for a masked AND gadget: splits a/b into Boolean shares
// and supplies fresh gadget randomness from a 64-bit Galois LFSR. Optional FEEDER_OP_COUNT_EN adds ops_done.
module mask_share_feeder #(
    parameter int          W        = 1,
    parameter logic [63:0] SEED_RST = 64'h1
) (
    input  logic         g_clk,
    input  logic         g_resetn,
    input  logic         seed_we,
    input  logic [63:0]  seed,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] ax,
    output logic [W-1:0] ay,
    output logic [W-1:0] bx,
    output logic [W-1:0] by,
    output logic [W-1:0] z0,
    output logic [W-1:0] z1,
    output logic         clk_en,
    output logic         out_valid,
    input  logic         out_ready
`ifdef FEEDER_OP_COUNT_EN
    ,
    output logic [31:0]  ops_done
`endif
);

    typedef enum logic [1:0] {
        ST_UNSEEDED,
        ST_IDLE,
        ST_LOAD,
        ST_EVAL
    } state_t;

    // Right-shifting Galois form of x^64+x^63+x^61+x^60+1.
    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    state_t        state_q, state_d;
    logic [63:0]   lfsr_q, lfsr_d;
    logic [W-1:0]  ax_q, ay_q, bx_q, by_q, z0_q, z1_q;
    logic          accept;
    logic          finish;

    assign accept = in_valid && (state_q == ST_IDLE);
    assign finish = out_ready && (state_q == ST_EVAL);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_UNSEEDED: if (seed_we)   state_d = ST_IDLE;
            ST_IDLE:     if (in_valid)  state_d = ST_LOAD;
            ST_LOAD:                    state_d = ST_EVAL;
            ST_EVAL:     if (out_ready) state_d = ST_IDLE;
            default:                    state_d = ST_UNSEEDED;
        endcase
    end

    // A zero seed would lock the LFSR, so it is replaced by 1.
    always_comb begin
        lfsr_d = lfsr_q;
        if (seed_we) begin
            lfsr_d = (seed == 64'h0) ? 64'h1 : seed;
        end else if (state_q != ST_UNSEEDED) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 64'h0);
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q <= ST_UNSEEDED;
            lfsr_q  <= SEED_RST;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
        end
    end

    // Shares are wiped when the gadget result is consumed so IDLE never exposes stale values.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            ax_q <= '0;
            ay_q <= '0;
            bx_q <= '0;
            by_q <= '0;
            z0_q <= '0;
            z1_q <= '0;
        end else if (accept) begin
            ax_q <= a ^ lfsr_q[0 +: W];
            ay_q <= lfsr_q[0 +: W];
            bx_q <= b ^ lfsr_q[16 +: W];
            by_q <= lfsr_q[16 +: W];
            z0_q <= lfsr_q[32 +: W];
            z1_q <= lfsr_q[48 +: W];
        end else if (finish) begin
            ax_q <= '0;
            ay_q <= '0;
            bx_q <= '0;
            by_q <= '0;
            z0_q <= '0;
            z1_q <= '0;
        end
    end

    assign ax        = ax_q;
    assign ay        = ay_q;
    assign bx        = bx_q;
    assign by        = by_q;
    assign z0        = z0_q;
    assign z1        = z1_q;
    assign in_ready  = (state_q == ST_IDLE);
    assign clk_en    = (state_q == ST_LOAD);
    assign out_valid = (state_q == ST_EVAL);

`ifdef FEEDER_OP_COUNT_EN
    logic [31:0] ops_q;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            ops_q <= 32'h0;
        end else if (finish) begin
            ops_q <= ops_q + 32'h1;
        end
    end

    assign ops_done = ops_q;
`endif

endmodule

// File: tb/tb_mask_share_feeder.sv
// Directed bench for mask_share_feeder: shares are checked against an independent
// bit-level LFSR reference; define FEEDER_OP_COUNT_EN to also exercise ops_done.
module tb_mask_share_feeder;

    localparam int          W        = 1;
    localparam logic [63:0] SEED_RST = 64'h1;

    logic         g_clk = 1'b0;
    logic         g_resetn;
    logic         seed_we;
    logic [63:0]  seed;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic [W-1:0] ax, ay, bx, by, z0, z1;
    logic         clk_en;
    logic         out_valid;
    logic         out_ready;
`ifdef FEEDER_OP_COUNT_EN
    logic [31:0]  ops_done;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [6*W-1:0] sh;
    assign sh = {ax, ay, bx, by, z0, z1};

    mask_share_feeder #(.W(W), .SEED_RST(SEED_RST)) dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .seed_we   (seed_we),
        .seed      (seed),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ax        (ax),
        .ay        (ay),
        .bx        (bx),
        .by        (by),
        .z0        (z0),
        .z1        (z1),
        .clk_en    (clk_en),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef FEEDER_OP_COUNT_EN
        ,
        .ops_done  (ops_done)
`endif
    );

    always #5 g_clk = ~g_clk;

    // Reference LFSR written tap-by-tap from the polynomial.
    function automatic logic [63:0] ref_step(input logic [63:0] l);
        logic [63:0] n;
        logic        fb;
        fb    = l[0];
        n     = l >> 1;
        n[63] = fb;
        n[62] = l[63] ^ fb;
        n[60] = l[61] ^ fb;
        n[59] = l[60] ^ fb;
        return n;
    endfunction

    logic [63:0] m_lfsr;
    logic        m_seeded;

    always @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            m_lfsr   <= SEED_RST;
            m_seeded <= 1'b0;
        end else if (seed_we) begin
            m_lfsr   <= (seed == 64'h0) ? 64'h1 : seed;
            m_seeded <= 1'b1;
        end else if (m_seeded) begin
            m_lfsr <= ref_step(m_lfsr);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    logic seen_z0_0, seen_z0_1;

    // One full operation; eval_hold = EVAL cycles with out_ready low before it is raised.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input int eval_hold,
                          input bit seed_at_accept, input bit seed_in_load);
        logic [63:0]    l;
        logic [W-1:0]   ra, rb;
        logic [6*W-1:0] exp_sh;
        check_eq("idle_in_ready", in_ready, 1);
        l      = m_lfsr;
        ra     = l[0 +: W];
        rb     = l[16 +: W];
        exp_sh = {av ^ ra, ra, bv ^ rb, rb, l[32 +: W], l[48 +: W]};
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        if (seed_at_accept) begin
            seed_we = 1'b1;
            seed    = 64'hFEED_FACE_CAFE_BEEF;
        end
        tick();
        in_valid = 1'b0;
        seed_we  = 1'b0;
        check_eq("load_clk_en", clk_en, 1);
        check_eq("load_out_valid", out_valid, 0);
        check_eq("load_in_ready", in_ready, 0);
        check_eq("load_shares", sh, exp_sh);
        check_eq("load_a_recombine", ax ^ ay, av);
        check_eq("load_b_recombine", bx ^ by, bv);
        if (z0 == '0) seen_z0_0 = 1'b1;
        else          seen_z0_1 = 1'b1;
        out_ready = 1'b1;
        if (seed_in_load) begin
            seed_we = 1'b1;
            seed    = 64'h0BAD_F00D_1234_5678;
        end
        tick();
        seed_we   = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < eval_hold; i++) begin
            check_eq("eval_hold_valid", out_valid, 1);
            check_eq("eval_hold_clk_en", clk_en, 0);
            check_eq("eval_hold_shares", sh, exp_sh);
            tick();
        end
        out_ready = 1'b1;
        check_eq("eval_valid", out_valid, 1);
        check_eq("eval_clk_en", clk_en, 0);
        check_eq("eval_shares", sh, exp_sh);
        tick();
        out_ready = 1'b0;
        check_eq("done_out_valid", out_valid, 0);
        check_eq("done_in_ready", in_ready, 1);
        check_eq("done_shares_zero", sh, 0);
    endtask

    initial begin
        g_resetn  = 1'b0;
        seed_we   = 1'b0;
        seed      = 64'h0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        seen_z0_0 = 1'b0;
        seen_z0_1 = 1'b0;
        #3;
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_clk_en", clk_en, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_shares", sh, 0);
`ifdef FEEDER_OP_COUNT_EN
        check_eq("rst_ops_done", ops_done, 0);
`endif
        tick();
        tick();
        g_resetn = 1'b1;

        // Unseeded: operands must be ignored.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("unseeded_in_ready", in_ready, 0);
            check_eq("unseeded_clk_en", clk_en, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        seed_we = 1'b1;
        seed    = 64'h0123_4567_89AB_CDEF;
        tick();
        seed_we = 1'b0;
        check_eq("seeded_in_ready", in_ready, 1);
        check_eq("seeded_shares_zero", sh, 0);

        run_op(1'b1, 1'b0, 5, 1'b0, 1'b0);

        // out_ready in IDLE must not disturb anything.
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        check_eq("idle_out_ready_in_ready", in_ready, 1);
        check_eq("idle_out_ready_valid", out_valid, 0);

        run_op(1'b1, 1'b1, 1, 1'b1, 1'b1);
        run_op(1'b0, 1'b1, 0, 1'b0, 1'b0);

        seed_we = 1'b1;
        seed    = 64'h0;
        tick();
        seed_we   = 1'b0;
        seen_z0_0 = 1'b0;
        seen_z0_1 = 1'b0;
        for (int i = 0; i < 200; i++) begin
            run_op(W'($urandom_range(1, 0)), W'($urandom_range(1, 0)), 0, 1'b0, 1'b0);
        end
        check_eq("z0_not_constant", {seen_z0_0, seen_z0_1}, 2'b11);

        // Reset asserted in the middle of LOAD.
        in_valid = 1'b1;
        a        = 1'b1;
        b        = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq("pre_rst_load_clk_en", clk_en, 1);
        #2;
        g_resetn = 1'b0;
        #1;
        check_eq("midrst_clk_en", clk_en, 0);
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_shares", sh, 0);
        tick();
        g_resetn  = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("postrst_out_valid", out_valid, 0);
            check_eq("postrst_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        seed_we = 1'b1;
        seed    = 64'h5555_AAAA_0F0F_F0F0;
        tick();
        seed_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_op(1'b1, 1'b0, 0, 1'b0, 1'b0);
        end
`ifdef FEEDER_OP_COUNT_EN
        check_eq("ops_done_three", ops_done, 3);
        force dut.ops_q = 32'hFFFF_FFFF;
        #1;
        release dut.ops_q;
        run_op(1'b0, 1'b0, 0, 1'b0, 1'b0);
        check_eq("ops_done_wrap", ops_done, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
